// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan controller.
// Holds the FSM state type, default channel geometry and the wait-counter width helper.
package mux_scan_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int N_CH_DEF  = 8;
   localparam int SEL_W_DEF = 3;

   // Counter must reach MUX_LAT; a zero-latency mux still gets a 1-bit counter.
   function automatic int cnt_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Next-enabled-channel finder: lowest set mask bit strictly above cur (signed, -1 = first).
// Purely combinational, zero latency, no flow control.
module mux_scan_next_ch
   import mux_scan_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic [N_CH-1:0]  mask,
   input  logic [SEL_W:0]   cur,
   output logic [SEL_W-1:0] next_ch,
   output logic             found
);

   int cur_i;

   always_comb begin
      cur_i   = int'($signed(cur));
      next_ch = '0;
      found   = 1'b0;
      // Descending walk so the lowest qualifying channel wins.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i > cur_i)) begin
            next_ch = SEL_W'(i);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled mux channels in ascending order and assembles the sampled bits into a word.
// Latency n*(MUX_LAT+1) edges from accepted start to one-cycle valid; start ignored while busy.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int N_CH    = N_CH_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int MUX_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_CH-1:0]  chan_mask,
   input  logic             mux_out,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic [N_CH-1:0]  data,
   output logic             valid
);

   localparam int               CNT_W    = cnt_width(MUX_LAT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUX_LAT);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [N_CH-1:0]  mask_q;
   logic [SEL_W-1:0] first_ch;
   logic [SEL_W-1:0] next_ch;
   logic             first_found;
   logic             next_found;

   // First channel is looked up from the live mask so sel is correct on the accept edge.
   mux_scan_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first (
      .mask    (chan_mask),
      .cur     ({(SEL_W + 1){1'b1}}),
      .next_ch (first_ch),
      .found   (first_found)
   );

   mux_scan_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_next (
      .mask    (mask_q),
      .cur     ({1'b0, sel}),
      .next_ch (next_ch),
      .found   (next_found)
   );

   assign busy = (state == SCAN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sel    <= '0;
         cnt    <= '0;
         mask_q <= '0;
         data   <= '0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mask_q <= chan_mask;
                  data   <= '0;
                  cnt    <= '0;
                  if (first_found) begin
                     state <= SCAN;
                     sel   <= first_ch;
                  end else begin
                     valid <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (cnt == CNT_LAST) begin
                  data[sel] <= mux_out;
                  cnt       <= '0;
                  if (next_found) begin
                     sel <= next_ch;
                  end else begin
                     state <= IDLE;
                     valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: one controller on a registered mux, one on a combinational mux, same stimulus.
// Expected words and completion edges come from a per-scan timing model built from the mask.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] chan_mask;
   logic [7:0] a;

   logic [2:0] sel0, sel1;
   logic       busy0, busy1, valid0, valid1;
   logic [7:0] data0, data1;
   logic       mux_out0;
   logic       mux_out1 = 1'b0;

   always #5 clk = ~clk;

   assign mux_out0 = a[sel0];
   always @(posedge clk) mux_out1 <= a[sel1];

   mux_scan_ctrl #(.N_CH(8), .SEL_W(3), .MUX_LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask), .mux_out(mux_out0),
      .sel(sel0), .busy(busy0), .data(data0), .valid(valid0)
   );

   mux_scan_ctrl #(.N_CH(8), .SEL_W(3), .MUX_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask), .mux_out(mux_out1),
      .sel(sel1), .busy(busy1), .data(data1), .valid(valid1)
   );

   typedef struct {
      logic [7:0] dat;
      int         edge_n;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   int         lat[2] = '{0, 1};
   int         ecnt = 0;
   int         e0[2];
   int         bend[2];
   int         nch[2];
   int         chl[2][8];
   logic [2:0] sel_before[2];
   logic [2:0] sel_after[2];
   logic [7:0] last_data[2];
   int         n_checks = 0;
   int         n_fail = 0;

   always @(posedge clk) ecnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, ecnt, act, expv);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         e0[d]         = 0;
         bend[d]       = -1;
         nch[d]        = 0;
         sel_before[d] = 3'd0;
         sel_after[d]  = 3'd0;
         last_data[d]  = 8'h00;
      end
      q0.delete();
      q1.delete();
   endtask

   // A request reaching edge E is taken only by a controller whose last scan ended before E.
   task automatic model_start(input int edge_n, input logic [7:0] m);
      exp_t ex;
      int   n;
      for (int d = 0; d < 2; d++) begin
         if (edge_n > bend[d]) begin
            n = 0;
            sel_before[d] = sel_after[d];
            for (int i = 0; i < 8; i++) begin
               if (m[i]) begin
                  chl[d][n] = i;
                  n++;
               end
            end
            nch[d]  = n;
            e0[d]   = edge_n;
            bend[d] = edge_n + n * (lat[d] + 1);
            if (n > 0) sel_after[d] = 3'(chl[d][n-1]);
            ex.dat    = a & m;
            ex.edge_n = bend[d];
            if (d == 0) q0.push_back(ex);
            else        q1.push_back(ex);
         end
      end
   endtask

   task automatic check_dut(input int d, input logic [2:0] s, input logic b,
                            input logic [7:0] dat, input logic v);
      exp_t       ex;
      logic       exp_busy;
      logic [2:0] exp_sel;
      int         has;
      exp_busy = (nch[d] > 0) && (ecnt >= e0[d]) && (ecnt < bend[d]);
      if (ecnt < e0[d])  exp_sel = sel_before[d];
      else if (exp_busy) exp_sel = 3'(chl[d][(ecnt - e0[d]) / (lat[d] + 1)]);
      else               exp_sel = sel_after[d];
      chk($sformatf("busy%0d", d), {31'b0, b}, {31'b0, exp_busy});
      chk($sformatf("sel%0d", d), {29'b0, s}, {29'b0, exp_sel});
      has = (d == 0) ? q0.size() : q1.size();
      if (v) begin
         if (has == 0) begin
            chk($sformatf("valid%0d_unexpected", d), {31'b0, v}, 32'd0);
         end else begin
            ex = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("data%0d", d), {24'b0, dat}, {24'b0, ex.dat});
            chk($sformatf("valid%0d_edge", d), ecnt, ex.edge_n);
            last_data[d] = ex.dat;
         end
      end else begin
         if (has > 0) begin
            ex = (d == 0) ? q0[0] : q1[0];
            if (ex.edge_n <= ecnt) begin
               chk($sformatf("valid%0d_missing", d), {31'b0, v}, 32'd1);
               if (d == 0) void'(q0.pop_front());
               else        void'(q1.pop_front());
            end
         end
         if (!exp_busy) chk($sformatf("data%0d_hold", d), {24'b0, dat}, {24'b0, last_data[d]});
      end
   endtask

   always @(negedge clk) begin
      check_dut(0, sel0, busy0, data0, valid0);
      check_dut(1, sel1, busy1, data1, valid1);
   end

   task automatic cyc(input logic st, input logic [7:0] m);
      @(posedge clk);
      #1;
      start     = st;
      chan_mask = m;
      if (st && !rst) model_start(ecnt + 1, m);
   endtask

   function automatic logic both_idle();
      return (ecnt + 1 > bend[0]) && (ecnt + 1 > bend[1]);
   endfunction

   task automatic wait_idle();
      for (int k = 0; k < 40; k++) begin
         if (both_idle()) break;
         cyc(1'b0, 8'h00);
      end
   endtask

   initial begin
      logic [7:0] m;
      rst       = 1'b1;
      start     = 1'b0;
      chan_mask = 8'h00;
      a         = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Full scan, sparse mask, zero mask, combinational-path pattern.
      a = 8'hAB; cyc(1'b1, 8'hFF); cyc(1'b0, 8'h00); wait_idle();
      a = 8'hFF; cyc(1'b1, 8'h85); cyc(1'b0, 8'h00); wait_idle();
      cyc(1'b1, 8'h00); cyc(1'b0, 8'h00); wait_idle();
      cyc(1'b0, 8'h00);
      a = 8'h3C; cyc(1'b1, 8'hFF); cyc(1'b0, 8'h00); wait_idle();

      // Second request mid-scan with a different mask must be dropped.
      a = 8'h5A; cyc(1'b1, 8'hFF);
      repeat (4) cyc(1'b0, 8'h00);
      cyc(1'b1, 8'h0F);
      cyc(1'b0, 8'h00); wait_idle();

      // Held start: re-accepted in the cycle valid is high.
      a = 8'h96;
      repeat (10) cyc(1'b1, 8'h81);
      cyc(1'b0, 8'h00); wait_idle();

      // Reset in the middle of a full scan, then a clean scan.
      a = 8'hC3; cyc(1'b1, 8'hFF);
      repeat (6) cyc(1'b0, 8'h00);
      @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(1'b1, 8'hFF); cyc(1'b0, 8'h00); wait_idle();

      for (int it = 0; it < 400; it++) begin
         if (both_idle() && ($urandom % 4 == 0)) a = 8'($urandom);
         case ($urandom % 4)
            0:       m = 8'h00;
            1:       m = 8'hFF;
            default: m = 8'($urandom);
         endcase
         cyc(($urandom % 3) == 0, m);
      end

      cyc(1'b0, 8'h00);
      wait_idle();
      repeat (3) cyc(1'b0, 8'h00);
      chk("scoreboard_drained", q0.size() + q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Upstream controller for the registered 8:1 multiplexer (`multiplexer8_1`). It drives the mux `sel` input through every enabled channel and samples the mux `out` after the mux pipeline latency. It reassembles the sampled bits into a parallel word and reports completion with a one-cycle `valid` pulse. This lets the test and system layers read all eight mux inputs back through the single-bit mux path, for readback and self-check.

## Interface
Parameters:
- `N_CH`, 8: number of mux channels; must be a power of two.
- `SEL_W`, 3: select width; equals log2(`N_CH`).
- `MUX_LAT`, 1: clock edges between a `sel` change and `out` reflecting it. 0 means a combinational mux; 1 means the registered `multiplexer8_1`.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: scan request, sampled on the rising edge; ignored while `busy`.
- `chan_mask`, input, `N_CH`: enabled channels; latched on the rising edge that accepts `start`.
- `mux_out`, input, 1: the mux `out` signal.
- `sel`, output, `SEL_W`: drives the mux `sel`.
- `busy`, output, 1: high while a scan is in progress.
- `data`, output, `N_CH`: scan result; bit i is the sample of channel i; masked bits are 0.
- `valid`, output, 1: one-cycle pulse when `data` is updated.

## Operation
- States:
  - IDLE: `busy`=0.
  - SCAN: `busy`=1.
- IDLE with `start`=1:
  - Latch `chan_mask`.
  - If the mask is nonzero, go to SCAN, set `sel` to the lowest enabled channel and clear the wait counter.
  - If the mask is zero, stay in IDLE, load `data`=0 and pulse `valid`.
- SCAN:
  - Hold `sel` while the wait counter counts up to `MUX_LAT`.
  - At that edge, write `data[sel]`=`mux_out` and clear the counter.
  - If a higher enabled channel exists, step `sel` to it; otherwise go to IDLE and pulse `valid`.
- Channel order is always ascending; disabled channels are skipped with zero cycles spent on them.
- `data` is cleared to 0 on the accepting edge of `start` and holds its final value until the next accepted `start`.
- `start` while SCAN is ignored and has no effect on the mask or the result.
- `start` in the cycle where `valid`=1 is accepted, because the block is already in IDLE.

## Timing
- Reset values: state IDLE, `sel`=0, `busy`=0, `data`=0, `valid`=0, wait counter 0, latched mask 0.
- Reset mid-scan aborts immediately. No `valid` pulse follows, and `data` reads 0.
- Accept edge is E0. Channel k in scan order is sampled at edge E0 + (k+1)·(`MUX_LAT`+1).
- Latency from start to `valid` is n·(`MUX_LAT`+1) edges, where n is the number of enabled channels. Full scan with `MUX_LAT`=1: `valid` is high in the cycle after edge E0+16.
- `busy` falls and `valid` rises on the same edge. `valid` is never high for more than one cycle.
- `sel` changes only on the edge that takes the sample, or on the accept edge. It is therefore stable for the mux for `MUX_LAT`+1 cycles per channel.
- With the mask zero, `valid` rises one cycle after the accept edge and `busy` never rises.

## Structure
- Package `mux_scan_pkg` holds:
  - the state enum (IDLE, SCAN);
  - default `N_CH`/`SEL_W` constants;
  - the wait-counter width, sized to hold `MUX_LAT`.
- Sub-module `mux_scan_next_ch` (combinational): inputs are the mask and the current channel. Outputs are the next higher enabled channel and a `found` flag. The same logic with the current channel forced to −1 gives the first enabled channel.
- Top level holds the FSM, wait counter, mask register and data register.

## Test plan
- Full scan: A=8'b10101011, mux `MUX_LAT`=1, mask 8'hFF, `start` pulse → `sel` steps 0..7 every 2 cycles; `valid` after 16 edges; `data`=8'hAB.
- Sparse mask: A=8'hFF, mask 8'b10000101 → `sel` visits 0, 2, 7 only; `valid` after 6 edges; `data`=8'h85.
- Zero mask: mask 8'h00, `start` → `busy` stays 0; `valid` pulses one cycle later; `data`=0.
- `start` during SCAN: second `start` at cycle 5 with a different mask → ignored; result and latency match the first request.
- Reset mid-scan: assert `rst` at cycle 7 of a full scan → all outputs go to their reset values immediately and no `valid` follows. A new `start` after reset release completes normally.
- `MUX_LAT`=0 with a combinational mux model: mask 8'hFF, A=8'h3C → one cycle per channel; `valid` after 8 edges; `data`=8'h3C.
